register_read_unit: RTL
=======================

# register_read_unit

Register file with scoreboard and read-operand stage for the RISC-V pipeline, sitting between decode and execute. It is the consumer-side counterpart of the write-back stage. It accepts write-back results and tracks registers with writes still in flight. It stalls decode on hazards and delivers registered source operands to execute over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, register width
- REG_ADD_WIDTH, 5, register address width
- REG_COUNT, 32, number of architectural registers (x0..x(REG_COUNT-1))

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- READ_VALID  input  1  decode presents an instruction
- READ_READY  output  1  unit accepts the instruction this cycle (combinational)
- RS1_ADDRESS  input  REG_ADD_WIDTH  source 1 index
- RS2_ADDRESS  input  REG_ADD_WIDTH  source 2 index
- RD_ADDRESS  input  REG_ADD_WIDTH  destination index
- RD_WRITE  input  1  instruction will write RD_ADDRESS
- WB_VALID  input  1  write-back result present
- WB_ADDRESS  input  REG_ADD_WIDTH  write-back destination
- WB_DATA  input  DATA_WIDTH  write-back value
- OUT_VALID  output  1  operands valid for execute
- OUT_READY  input  1  execute accepts operands
- RS1_DATA  output  DATA_WIDTH  registered operand 1
- RS2_DATA  output  DATA_WIDTH  registered operand 2

## Operation
- Storage: REG_COUNT x DATA_WIDTH array plus REG_COUNT-bit PENDING vector.
- x0: reads return 0. Writes to x0 are ignored. PENDING[0] is never set.
- Write: WB_VALID && WB_ADDRESS!=0 writes WB_DATA to the array and clears PENDING[WB_ADDRESS] at the clock edge.
- Per-source "clear" this cycle: the index is 0, or PENDING is 0, or (WB_VALID && WB_ADDRESS==index).
- Operand select: if WB_VALID && WB_ADDRESS==index && index!=0, select WB_DATA (same-cycle bypass). Otherwise select the array value, or 0 for x0.
- WAW check: if RD_WRITE && RD_ADDRESS!=0, the RD_ADDRESS must also be clear by the same rule.
- Output slot free: !OUT_VALID || OUT_READY.
- READ_READY = all required registers clear && output slot free. READ_READY does not depend on READ_VALID.
- Issue (READ_VALID && READ_READY):
  - Latch the selected operands into RS1_DATA/RS2_DATA.
  - Set OUT_VALID.
  - If RD_WRITE && RD_ADDRESS!=0, set PENDING[RD_ADDRESS].
- Simultaneous set and clear of the same PENDING bit (issue plus write-back to the same register): set wins.
- Output handshake:
  - OUT_VALID && OUT_READY with no new issue clears OUT_VALID.
  - While OUT_VALID && !OUT_READY, RS1_DATA/RS2_DATA/OUT_VALID hold.
- Output state machine: EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
  - EMPTY -> FULL on issue.
  - FULL -> FULL on OUT_READY with issue, or on hold.
  - FULL -> EMPTY on OUT_READY without issue.

## Timing
- Reset: array all 0, PENDING all 0, OUT_VALID=0, RS1_DATA=RS2_DATA=0. READ_READY=1 after reset.
- Reset is asynchronous. Asserting it mid-operation drops OUT_VALID immediately and discards all pending state. A write-back arriving in the reset cycle is lost.
- Latency: operands appear on RS*_DATA with OUT_VALID one cycle after the issue handshake.
- Write-back to read: same-cycle, through the bypass. A write in cycle N is visible in operands issued in cycle N.
- Stall release: a RAW/WAW stall ends in the cycle the matching WB_VALID arrives, not one cycle later.
- Throughput: one instruction per cycle when OUT_READY=1 and no hazards.
- Multiple pending writes to one register cannot occur, because the WAW check enforces at most one outstanding writer per register.
- WB_VALID to a non-pending register still writes the array and is legal.

## Test plan
- Reset, then issue rs1=5, rs2=0 -> READ_READY=1; next cycle OUT_VALID=1, RS1_DATA=0, RS2_DATA=0.
- WB x7=0xDEADBEEF; next cycle issue rs1=7 -> RS1_DATA=0xDEADBEEF one cycle later.
- Issue with rd=3; then issue rs2=3 with no WB -> READ_READY=0 for 4 cycles. On cycle 5, WB x3=0x12345678 -> READ_READY=1 that cycle; the next cycle RS2_DATA=0x12345678; PENDING[3]=0.
- Issue with rd=0, then rs1=0; also WB x0=0xFFFFFFFF -> no stall; RS1_DATA=0.
- OUT_READY=0 for 3 cycles after an issue -> OUT_VALID and data hold, READ_READY=0. Raise OUT_READY -> the next instruction issues in the same cycle, and OUT_VALID stays 1.
- Pending rd=9; issue rd=9 (WAW) -> stalled. On the cycle WB x9 arrives, the issue proceeds and PENDING[9]=1 afterward (set wins). Assert RST mid-stream -> OUT_VALID=0 immediately and PENDING cleared.

Source files
------------

// File: rtl/register_read_unit.sv
`default_nettype none
// ============================================================================
//  Module   : register_read_unit
//  Purpose  : Register file, in-flight write scoreboard and read-operand stage
//             between decode and execute. Accepts write-back results, stalls
//             decode on RAW/WAW hazards and delivers registered operands to
//             execute over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK          in   1              clock, rising edge
//    RST          in   1              asynchronous active-high reset
//    READ_VALID   in   1              decode presents an instruction
//    READ_READY   out  1              instruction accepted this cycle (comb)
//    RS1_ADDRESS  in   REG_ADD_WIDTH  source 1 index
//    RS2_ADDRESS  in   REG_ADD_WIDTH  source 2 index
//    RD_ADDRESS   in   REG_ADD_WIDTH  destination index
//    RD_WRITE     in   1              instruction writes RD_ADDRESS
//    WB_VALID     in   1              write-back result present
//    WB_ADDRESS   in   REG_ADD_WIDTH  write-back destination
//    WB_DATA      in   DATA_WIDTH     write-back value
//    OUT_VALID    out  1              operands valid for execute
//    OUT_READY    in   1              execute accepts operands
//    RS1_DATA     out  DATA_WIDTH     registered operand 1
//    RS2_DATA     out  DATA_WIDTH     registered operand 2
// ============================================================================
module register_read_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADD_WIDTH = 5,
  parameter int REG_COUNT     = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     READ_VALID,
  output logic                     READ_READY,
  input  logic [REG_ADD_WIDTH-1:0] RS1_ADDRESS,
  input  logic [REG_ADD_WIDTH-1:0] RS2_ADDRESS,
  input  logic [REG_ADD_WIDTH-1:0] RD_ADDRESS,
  input  logic                     RD_WRITE,
  input  logic                     WB_VALID,
  input  logic [REG_ADD_WIDTH-1:0] WB_ADDRESS,
  input  logic [DATA_WIDTH-1:0]    WB_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [DATA_WIDTH-1:0]    RS1_DATA,
  output logic [DATA_WIDTH-1:0]    RS2_DATA
);

  // Output slot state: EMPTY means no operands held for execute.
  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [DATA_WIDTH-1:0]   r_regs [REG_COUNT];
  logic [REG_COUNT-1:0]    r_pending;
  logic [REG_COUNT-1:0]    w_pending_next;

  logic                    w_wb_write;
  logic                    w_rs1_clear;
  logic                    w_rs2_clear;
  logic                    w_rd_need;
  logic                    w_rd_clear;
  logic                    w_slot_free;
  logic                    w_issue;
  logic [DATA_WIDTH-1:0]   w_rs1_sel;
  logic [DATA_WIDTH-1:0]   w_rs2_sel;

  // Writes to x0 are dropped everywhere.
  assign w_wb_write = WB_VALID && (WB_ADDRESS != '0);

  // A register is clear when it is x0, has no writer in flight, or its
  // writer is completing this very cycle (stall releases without delay).
  assign w_rs1_clear = (RS1_ADDRESS == '0) || !r_pending[RS1_ADDRESS] ||
                       (WB_VALID && (WB_ADDRESS == RS1_ADDRESS));
  assign w_rs2_clear = (RS2_ADDRESS == '0) || !r_pending[RS2_ADDRESS] ||
                       (WB_VALID && (WB_ADDRESS == RS2_ADDRESS));

  // WAW: a second writer to the same register waits for the first.
  assign w_rd_need  = RD_WRITE && (RD_ADDRESS != '0);
  assign w_rd_clear = !r_pending[RD_ADDRESS] ||
                      (WB_VALID && (WB_ADDRESS == RD_ADDRESS));

  assign w_slot_free = !OUT_VALID || OUT_READY;

  // READ_READY intentionally ignores READ_VALID so decode can use it freely.
  assign READ_READY = w_rs1_clear && w_rs2_clear &&
                      (!w_rd_need || w_rd_clear) && w_slot_free;

  assign w_issue = READ_VALID && READ_READY;

  // Operand select with same-cycle write-back bypass.
  always_comb begin
    w_rs1_sel = '0;
    if (RS1_ADDRESS != '0) begin
      if (WB_VALID && (WB_ADDRESS == RS1_ADDRESS)) begin
        w_rs1_sel = WB_DATA;
      end else begin
        w_rs1_sel = r_regs[RS1_ADDRESS];
      end
    end
  end

  always_comb begin
    w_rs2_sel = '0;
    if (RS2_ADDRESS != '0) begin
      if (WB_VALID && (WB_ADDRESS == RS2_ADDRESS)) begin
        w_rs2_sel = WB_DATA;
      end else begin
        w_rs2_sel = r_regs[RS2_ADDRESS];
      end
    end
  end

  // Scoreboard update. Set is applied after clear so a new writer issued in
  // the same cycle its predecessor retires keeps the bit set.
  always_comb begin
    w_pending_next = r_pending;
    if (w_wb_write) begin
      w_pending_next[WB_ADDRESS] = 1'b0;
    end
    if (w_issue && w_rd_need) begin
      w_pending_next[RD_ADDRESS] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Register array; entry 0 is never written and reads of x0 bypass it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_write) begin
      r_regs[WB_ADDRESS] <= WB_DATA;
    end
  end

  // Operand registers only load on issue, so they hold under backpressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RS1_DATA <= '0;
      RS2_DATA <= '0;
    end else if (w_issue) begin
      RS1_DATA <= w_rs1_sel;
      RS2_DATA <= w_rs2_sel;
    end
  end

  // Output slot state machine.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_issue) begin
          w_state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (OUT_READY && !w_issue) begin
          w_state_next = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  assign OUT_VALID = (r_state == S_FULL);

endmodule
`default_nettype wire
